// File: rtl/tpu_seq_ctrl.sv
// Sequencer between TPU decode and the systolic array: issues registered buffer
// load/read enables in IDLE and runs the fixed-length skewed matmul schedule.
module tpu_seq_ctrl #(
  parameter  int DIM        = 4,
  localparam int RUN_CYCLES = 3*DIM-2,
  localparam int CNT_W      = $clog2(3*DIM),
  localparam int RW         = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tpu_start_i,
  input  logic             tpu_we_a_i,
  input  logic             tpu_we_b_i,
  input  logic             tpu_we_c_i,
  input  logic             tpu_rd_c_i,
  input  logic [RW-1:0]    row_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             a_wr_en_o,
  output logic             b_wr_en_o,
  output logic             c_wr_en_o,
  output logic             c_rd_en_o,
  output logic [RW-1:0]    row_addr_o,
  output logic             shift_en_o,
  output logic [CNT_W-1:0] feed_idx_o,
  output logic             acc_wb_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_CYCLES-1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             any_strobe, multi_strobe;
  logic             go_start, go_a, go_b, go_c, go_rd;
  logic [RW-1:0]    row_clamped;

  // Handshake: decode holds a TPU strobe until a cycle with stall_o=0; the
  // strobe is consumed exactly in that cycle, and only the highest-priority one.
  assign any_strobe   = tpu_start_i | tpu_we_a_i | tpu_we_b_i | tpu_we_c_i | tpu_rd_c_i;
  assign multi_strobe = $countones({tpu_start_i, tpu_we_a_i, tpu_we_b_i,
                                    tpu_we_c_i, tpu_rd_c_i}) > 1;

  assign busy_o  = (state != IDLE);
  assign stall_o = busy_o & any_strobe;

  assign go_start = ~busy_o & tpu_start_i;
  assign go_a     = ~busy_o & ~tpu_start_i & tpu_we_a_i;
  assign go_b     = ~busy_o & ~tpu_start_i & ~tpu_we_a_i & tpu_we_b_i;
  assign go_c     = ~busy_o & ~tpu_start_i & ~tpu_we_a_i & ~tpu_we_b_i & tpu_we_c_i;
  assign go_rd    = ~busy_o & ~tpu_start_i & ~tpu_we_a_i & ~tpu_we_b_i & ~tpu_we_c_i
                    & tpu_rd_c_i;

  // Only matters when DIM is not a power of two.
  always_comb begin
    row_clamped = row_i;
    if (int'(row_i) > DIM-1) row_clamped = RW'(DIM-1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end else if (cnt > LAST) begin
      cnt <= LAST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wr_en_o  <= 1'b0;
      b_wr_en_o  <= 1'b0;
      c_wr_en_o  <= 1'b0;
      c_rd_en_o  <= 1'b0;
      row_addr_o <= '0;
      err_o      <= 1'b0;
    end else begin
      a_wr_en_o <= go_a;
      b_wr_en_o <= go_b;
      c_wr_en_o <= go_c;
      c_rd_en_o <= go_rd;
      if (go_a | go_b | go_c | go_rd) row_addr_o <= row_clamped;
      if (multi_strobe) err_o <= 1'b1;
    end
  end

  assign shift_en_o = (state == RUN);
  assign feed_idx_o = (state == RUN) ? cnt : '0;
  assign acc_wb_o   = (state == DRAIN);
  assign done_o     = (state == DRAIN);

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl (DIM=4): idle, loads, matmul timing, stall,
// mid-run reset and illegal multi-strobe behaviour.
module tb_tpu_seq_ctrl;

  localparam int DIM   = 4;
  localparam int CNT_W = $clog2(3*DIM);
  localparam int RW    = $clog2(DIM);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tpu_start_i, tpu_we_a_i, tpu_we_b_i, tpu_we_c_i, tpu_rd_c_i;
  logic [RW-1:0]    row_i;
  logic             stall_o, busy_o, a_wr_en_o, b_wr_en_o, c_wr_en_o, c_rd_en_o;
  logic [RW-1:0]    row_addr_o;
  logic             shift_en_o, acc_wb_o, done_o, err_o;
  logic [CNT_W-1:0] feed_idx_o;

  int total    = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  tpu_seq_ctrl #(.DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .tpu_start_i(tpu_start_i), .tpu_we_a_i(tpu_we_a_i), .tpu_we_b_i(tpu_we_b_i),
    .tpu_we_c_i(tpu_we_c_i), .tpu_rd_c_i(tpu_rd_c_i), .row_i(row_i),
    .stall_o(stall_o), .busy_o(busy_o), .a_wr_en_o(a_wr_en_o), .b_wr_en_o(b_wr_en_o),
    .c_wr_en_o(c_wr_en_o), .c_rd_en_o(c_rd_en_o), .row_addr_o(row_addr_o),
    .shift_en_o(shift_en_o), .feed_idx_o(feed_idx_o), .acc_wb_o(acc_wb_o),
    .done_o(done_o), .err_o(err_o)
  );

  function automatic logic [31:0] outs();
    return {16'd0, stall_o, busy_o, a_wr_en_o, b_wr_en_o, c_wr_en_o, c_rd_en_o,
            shift_en_o, acc_wb_o, done_o, err_o, row_addr_o, feed_idx_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance into the next cycle; inputs driven after this apply to that cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    tpu_start_i = 1'b0; tpu_we_a_i = 1'b0; tpu_we_b_i = 1'b0;
    tpu_we_c_i  = 1'b0; tpu_rd_c_i = 1'b0;
  endtask

  // Start in cycle 0 (optionally with an illegal we_c alongside), check cycles 1..12.
  task automatic run_mm(input string tag, input logic extra_c, input logic exp_err);
    cyc();
    tpu_start_i = 1'b1;
    tpu_we_c_i  = extra_c;
    @(negedge clk);
    chk($sformatf("%s_stall0", tag), 32'(stall_o), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      clr_strobes();
      @(negedge clk);
      chk($sformatf("%s_busy%0d", tag, k),  32'(busy_o),     32'(k <= 11));
      chk($sformatf("%s_shift%0d", tag, k), 32'(shift_en_o), 32'(k <= 10));
      chk($sformatf("%s_feed%0d", tag, k),  32'(feed_idx_o), (k <= 10) ? 32'(k-1) : 32'd0);
      chk($sformatf("%s_done%0d", tag, k),  32'(done_o),     32'(k == 11));
      chk($sformatf("%s_accwb%0d", tag, k), 32'(acc_wb_o),   32'(k == 11));
      chk($sformatf("%s_cwr%0d", tag, k),   32'(c_wr_en_o),  32'd0);
      chk($sformatf("%s_err%0d", tag, k),   32'(err_o),      32'(exp_err));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    row_i = '0;
    clr_strobes();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Quiet idle
    for (int i = 0; i < 20; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("idle_outs%0d", i), outs(), 32'd0);
    end

    // Back-to-back loads in IDLE
    cyc(); tpu_we_a_i = 1'b1; row_i = 2'd2;
    @(negedge clk);
    chk("load_stall_t", 32'(stall_o), 32'd0);
    cyc(); tpu_we_a_i = 1'b0; tpu_we_b_i = 1'b1; row_i = 2'd3;
    @(negedge clk);
    chk("load_a_en", 32'(a_wr_en_o), 32'd1);
    chk("load_a_row", 32'(row_addr_o), 32'd2);
    chk("load_b_early", 32'(b_wr_en_o), 32'd0);
    chk("load_stall_t1", 32'(stall_o), 32'd0);
    cyc(); tpu_we_b_i = 1'b0;
    @(negedge clk);
    chk("load_b_en", 32'(b_wr_en_o), 32'd1);
    chk("load_b_row", 32'(row_addr_o), 32'd3);
    chk("load_a_once", 32'(a_wr_en_o), 32'd0);
    cyc();
    @(negedge clk);
    chk("load_b_once", 32'(b_wr_en_o), 32'd0);

    // Accumulator load and read in IDLE
    cyc(); tpu_we_c_i = 1'b1; row_i = 2'd1;
    cyc(); tpu_we_c_i = 1'b0; tpu_rd_c_i = 1'b1; row_i = 2'd0;
    @(negedge clk);
    chk("lacc_en", 32'(c_wr_en_o), 32'd1);
    chk("lacc_row", 32'(row_addr_o), 32'd1);
    cyc(); tpu_rd_c_i = 1'b0;
    @(negedge clk);
    chk("racc_en", 32'(c_rd_en_o), 32'd1);
    chk("racc_row", 32'(row_addr_o), 32'd0);

    // Matmul timing
    run_mm("mm", 1'b0, 1'b0);

    // Stall: rd_c held from cycle 5 until accepted in the first IDLE cycle (12)
    cyc(); tpu_start_i = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      tpu_start_i = 1'b0;
      tpu_rd_c_i  = (k >= 5 && k <= 12);
      row_i       = 2'd1;
      @(negedge clk);
      chk($sformatf("stall_%0d", k), 32'(stall_o), 32'(k >= 5 && k <= 11));
      chk($sformatf("stall_rden%0d", k), 32'(c_rd_en_o), 32'(k == 13));
      if (k == 13) chk("stall_row", 32'(row_addr_o), 32'd1);
    end

    // Reset in the sixth RUN cycle
    cyc(); tpu_start_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      clr_strobes();
    end
    @(negedge clk);
    chk("pre_rst_shift", 32'(shift_en_o), 32'd1);
    chk("pre_rst_feed", 32'(feed_idx_o), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate", outs(), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("rst_hold%0d", k), outs(), 32'd0);
    end
    cyc(); rst_n = 1'b1;
    run_mm("rerun", 1'b0, 1'b0);

    // Illegal start+we_c: start wins, err sticks
    run_mm("illegal", 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("err_sticky%0d", k), 32'(err_o), 32'd1);
    end

    // Priority in IDLE: we_a beats we_b
    cyc(); tpu_we_a_i = 1'b1; tpu_we_b_i = 1'b1; row_i = 2'd3;
    cyc(); clr_strobes();
    @(negedge clk);
    chk("prio_a", 32'(a_wr_en_o), 32'd1);
    chk("prio_b", 32'(b_wr_en_o), 32'd0);
    chk("prio_row", 32'(row_addr_o), 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
